// File: rtl/mcmc_solver_ctrl.sv
// Iteration controller for the MCMC constraint solver.
// Holds the working assignment, requests one proposal per iteration from the
// probabilistic-search datapath, and commits accepted moves. It captures the
// first satisfying assignment and stops on success or when the iteration limit
// is reached. An 8-bit LFSR compared against pls0 picks random-walk or
// local-search mode for each request.
module mcmc_solver_ctrl #(
  parameter int          NUM_BOOL  = 4,
  parameter int          NUM_INT   = 4,
  parameter int          INT_W     = 8,
  parameter int          ITER_W    = 16,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ITER_W-1:0]          max_iter,
  input  logic [7:0]                 in_pls0,
  input  logic [NUM_BOOL-1:0]        in_initial_boolean_assigmnets,
  input  logic [NUM_INT*INT_W-1:0]   in_initial_integer_assigmnets,
  input  logic                       in_initial_sat,
  output logic                       prop_req,
  output logic                       prop_mode,
  output logic [NUM_BOOL-1:0]        cur_boolean,
  output logic [NUM_INT*INT_W-1:0]   cur_integer,
  input  logic                       prop_ack,
  input  logic [NUM_BOOL-1:0]        prop_boolean,
  input  logic [NUM_INT*INT_W-1:0]   prop_integer,
  input  logic                       prop_accept,
  input  logic                       prop_sat,
  output logic                       busy,
  output logic                       done,
  output logic                       found,
  output logic [ITER_W-1:0]          iter_count,
  output logic [NUM_BOOL-1:0]        out_boolean_valid_solution,
  output logic [NUM_INT*INT_W-1:0]   out_integer_valid_solution
);

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

  // An all-zero seed would lock the LFSR, so substitute 1.
  localparam logic [7:0] LFSR_INIT = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  state_t            state_q, state_d;
  logic [7:0]        lfsr_q;
  logic [7:0]        pls0_q;
  logic [ITER_W-1:0] max_q;
  logic [ITER_W-1:0] iter_next;
  logic              hit_sat;
  logic              hit_limit;

  assign iter_next = iter_count + ITER_W'(1);
  assign hit_sat   = prop_accept & prop_sat;
  assign hit_limit = (max_q != '0) && (iter_next == max_q);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: one proposal handshake per iteration, GAP between.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = in_initial_sat ? DONE : REQ;
      REQ: begin
        if (prop_ack) begin
          if (hit_sat || hit_limit) state_d = DONE;
          else                      state_d = GAP;
        end
      end
      GAP:     state_d = REQ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: handshake and status strobes straight from the state.
  always_comb begin
    prop_req  = (state_q == REQ);
    prop_mode = (state_q == REQ) && (lfsr_q < pls0_q);
    busy      = (state_q == REQ) || (state_q == GAP);
    done      = (state_q == DONE);
  end

  // Datapath: latch the job on start, commit accepted moves, capture solution.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_boolean                <= '0;
      cur_integer                <= '0;
      pls0_q                     <= '0;
      max_q                      <= '0;
      iter_count                 <= '0;
      found                      <= 1'b0;
      out_boolean_valid_solution <= '0;
      out_integer_valid_solution <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cur_boolean <= in_initial_boolean_assigmnets;
            cur_integer <= in_initial_integer_assigmnets;
            pls0_q      <= in_pls0;
            max_q       <= max_iter;
            iter_count  <= '0;
            found       <= in_initial_sat;
            if (in_initial_sat) begin
              out_boolean_valid_solution <= in_initial_boolean_assigmnets;
              out_integer_valid_solution <= in_initial_integer_assigmnets;
            end
          end
        end
        REQ: begin
          if (prop_ack) begin
            iter_count <= iter_next;
            if (prop_accept) begin
              cur_boolean <= prop_boolean;
              cur_integer <= prop_integer;
            end
            // A satisfying proposal that was rejected is deliberately dropped.
            if (hit_sat) begin
              out_boolean_valid_solution <= prop_boolean;
              out_integer_valid_solution <= prop_integer;
              found                      <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Mode LFSR: Fibonacci taps 8,6,5,4; advances once per GAP cycle only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                lfsr_q <= LFSR_INIT;
    else if (state_q == GAP)  lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

endmodule

// File: tb/tb_mcmc_solver_ctrl.sv
// Directed bench for mcmc_solver_ctrl: initial-sat shortcut, iteration limit,
// capture on accept+sat, rejected-sat handling, LFSR mode selection, reset abort.
module tb_mcmc_solver_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] max_iter;
  logic [7:0]  in_pls0;
  logic [3:0]  in_b;
  logic [31:0] in_i;
  logic        in_sat;
  logic        prop_req, prop_mode;
  logic [3:0]  cur_boolean;
  logic [31:0] cur_integer;
  logic        prop_ack;
  logic [3:0]  prop_boolean;
  logic [31:0] prop_integer;
  logic        prop_accept, prop_sat;
  logic        busy, done, found;
  logic [15:0] iter_count;
  logic [3:0]  out_b;
  logic [31:0] out_i;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  m_lfsr = 8'hA5;

  mcmc_solver_ctrl dut (
    .clk                           (clk),
    .reset                         (reset),
    .start                         (start),
    .max_iter                      (max_iter),
    .in_pls0                       (in_pls0),
    .in_initial_boolean_assigmnets (in_b),
    .in_initial_integer_assigmnets (in_i),
    .in_initial_sat                (in_sat),
    .prop_req                      (prop_req),
    .prop_mode                     (prop_mode),
    .cur_boolean                   (cur_boolean),
    .cur_integer                   (cur_integer),
    .prop_ack                      (prop_ack),
    .prop_boolean                  (prop_boolean),
    .prop_integer                  (prop_integer),
    .prop_accept                   (prop_accept),
    .prop_sat                      (prop_sat),
    .busy                          (busy),
    .done                          (done),
    .found                         (found),
    .iter_count                    (iter_count),
    .out_boolean_valid_solution    (out_b),
    .out_integer_valid_solution    (out_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  // Called at a negedge; returns one negedge later with the job latched.
  task automatic do_start(input logic [7:0] pls0, input logic [15:0] mi,
                          input logic [3:0] b, input logic [31:0] iv, input logic sat);
    in_pls0 = pls0; max_iter = mi; in_b = b; in_i = iv; in_sat = sat; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!prop_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, 64'(prop_req), 64'd1);
  endtask

  // One proposal handshake; exp_gap selects GAP (continue) or DONE as outcome.
  task automatic ack(input string tag, input logic acc, input logic sat,
                     input logic [3:0] b, input logic [31:0] iv,
                     input logic exp_gap, input logic [7:0] pls0);
    wait_req(tag);
    check({tag, "_mode"}, 64'(prop_mode), 64'(m_lfsr < pls0));
    prop_ack = 1'b1; prop_accept = acc; prop_sat = sat; prop_boolean = b; prop_integer = iv;
    @(negedge clk);
    prop_ack = 1'b0; prop_accept = 1'b0; prop_sat = 1'b0;
    if (exp_gap) begin
      check({tag, "_gap"}, 64'({busy, prop_req, done}), 64'b100);
      m_lfsr = lfsr_step(m_lfsr);
    end else begin
      check({tag, "_done"}, 64'({busy, prop_req, done}), 64'b001);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({prop_req, prop_mode, busy, done, found}), 64'd0);
    check({tag, "_iter"}, 64'(iter_count), 64'd0);
    check({tag, "_cur"}, {28'd0, cur_boolean, cur_integer}, 64'd0);
    check({tag, "_out"}, {28'd0, out_b, out_i}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; max_iter = '0; in_pls0 = '0; in_b = '0; in_i = '0;
    in_sat = 1'b0; prop_ack = 1'b0; prop_boolean = '0; prop_integer = '0;
    prop_accept = 1'b0; prop_sat = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // T1: initial assignment already satisfies -> DONE next cycle.
    do_start(8'h40, 16'd0, 4'b0110, 32'h01020304, 1'b1);
    check("t1_strobes", 64'({prop_req, busy, done, found}), 64'b0011);
    check("t1_out", {28'd0, out_b, out_i}, {28'd0, 4'b0110, 32'h01020304});
    check("t1_iter", 64'(iter_count), 64'd0);
    @(negedge clk);
    check("t1_done_pulse", 64'({done, prop_req}), 64'd0);

    // T2: limit of 3, every move accepted but unsatisfying; pls0=0 -> local search.
    do_start(8'h00, 16'd3, 4'b0001, 32'h11223344, 1'b0);
    ack("t2a", 1'b1, 1'b0, 4'b0010, 32'hAAAA0001, 1'b1, 8'h00);
    check("t2a_cur", 64'(cur_boolean), 64'b0010);
    ack("t2b", 1'b1, 1'b0, 4'b0011, 32'hAAAA0002, 1'b1, 8'h00);
    ack("t2c", 1'b1, 1'b0, 4'b0100, 32'hAAAA0003, 1'b0, 8'h00);
    check("t2_found", 64'(found), 64'd0);
    check("t2_iter", 64'(iter_count), 64'd3);
    check("t2_cur", {28'd0, cur_boolean, cur_integer}, {28'd0, 4'b0100, 32'hAAAA0003});
    check("t2_out_hold", {28'd0, out_b, out_i}, {28'd0, 4'b0110, 32'h01020304});
    @(negedge clk);

    // T3: unlimited; second proposal accepted and satisfying.
    do_start(8'h00, 16'd0, 4'b1111, 32'h55555555, 1'b0);
    ack("t3a", 1'b0, 1'b0, 4'b0000, 32'h0, 1'b1, 8'h00);
    check("t3a_cur", 64'(cur_boolean), 64'b1111);
    ack("t3b", 1'b1, 1'b1, 4'b1010, 32'hDEADBEEF, 1'b0, 8'h00);
    check("t3_found", 64'(found), 64'd1);
    check("t3_out", {28'd0, out_b, out_i}, {28'd0, 4'b1010, 32'hDEADBEEF});
    check("t3_iter", 64'(iter_count), 64'd2);
    check("t3_cur", 64'(cur_boolean), 64'b1010);
    @(negedge clk);

    // T4: satisfying but rejected proposal is ignored; stray ack in GAP ignored.
    do_start(8'h00, 16'd2, 4'b0011, 32'h0BADF00D, 1'b0);
    ack("t4a", 1'b0, 1'b1, 4'b1100, 32'h12345678, 1'b1, 8'h00);
    check("t4a_cur", {28'd0, cur_boolean, cur_integer}, {28'd0, 4'b0011, 32'h0BADF00D});
    check("t4a_out", {28'd0, out_b, out_i}, {28'd0, 4'b1010, 32'hDEADBEEF});
    check("t4a_found", 64'(found), 64'd0);
    prop_ack = 1'b1; prop_accept = 1'b1; prop_sat = 1'b1; prop_boolean = 4'b1111;
    @(negedge clk);
    prop_ack = 1'b0; prop_accept = 1'b0; prop_sat = 1'b0;
    check("t4_stray_ack", 64'({found, cur_boolean, prop_req}), 64'({1'b0, 4'b0011, 1'b1}));
    check("t4_stray_iter", 64'(iter_count), 64'd1);
    ack("t4b", 1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 8'h00);
    check("t4_end", 64'({found, iter_count}), 64'({1'b0, 16'd2}));
    @(negedge clk);

    // T5: pls0=0x80, mode must follow the reference LFSR sequence.
    do_start(8'h80, 16'd6, 4'b0000, 32'h0, 1'b0);
    for (int k = 0; k < 6; k++)
      ack($sformatf("t5_%0d", k), 1'b0, 1'b0, 4'b0000, 32'h0, k < 5, 8'h80);
    check("t5_iter", 64'(iter_count), 64'd6);
    @(negedge clk);

    // T6: reset while waiting on a delayed ack aborts without done.
    do_start(8'hB0, 16'd0, 4'b1001, 32'hCAFEF00D, 1'b0);
    repeat (5) @(negedge clk);
    check("t6_waiting", 64'({prop_req, busy}), 64'b11);
    #2 reset = 1'b1;
    #1 check_all_zero("t6_async");
    m_lfsr = 8'hA5;
    prop_ack = 1'b1; prop_accept = 1'b1; prop_sat = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("t6_no_done", 64'(done), 64'd0);
    end
    prop_ack = 1'b0; prop_accept = 1'b0; prop_sat = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("t6_idle", 64'({busy, done}), 64'd0);
    do_start(8'hB0, 16'd0, 4'b0101, 32'h0, 1'b0);
    ack("t6r", 1'b1, 1'b1, 4'b0110, 32'h00000077, 1'b0, 8'hB0);
    check("t6_restart", {27'd0, found, out_b, out_i}, {27'd0, 1'b1, 4'b0110, 32'h00000077});
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
